// File: rtl/mux_arb_n.sv
// N-channel registered valid/ready multiplexer with fixed-select or round-robin arbitration.
// Optional transfer counter port xfer_cnt is enabled by defining MUX_ARB_STATS_EN.
module mux_arb_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
`ifdef MUX_ARB_STATS_EN
    output logic [15:0]        xfer_cnt,
`endif
    input  logic               out_ready
);

    logic [SELW-1:0]  ptr;
    logic             grant_ok;
    logic [SELW-1:0]  grant_idx;
    logic [N-1:0]     grant_vec;
    logic [WIDTH-1:0] grant_data;
    logic             load;
    logic             in_xfer;

    // Grant decision: external select in fixed mode, first requester from ptr in rr mode
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        if (mode) begin
            for (int k = 0; k < int'(N); k++) begin
                if (!grant_ok && in_valid[(int'(ptr) + k) % int'(N)]) begin
                    grant_ok  = 1'b1;
                    grant_idx = SELW'((int'(ptr) + k) % int'(N));
                end
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (SELW'(i) == sel && in_valid[i]) begin
                    grant_ok  = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_vec  = '0;
        grant_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant_ok && SELW'(i) == grant_idx) begin
                grant_vec[i] = 1'b1;
                grant_data   = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load     = !out_valid || out_ready;
    assign in_xfer  = grant_ok && load && !rst;
    assign in_ready = (load && !rst) ? grant_vec : '0;

    // Output register stage and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (in_xfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                if (mode) begin
                    ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed vector bench for mux_arb_n (WIDTH=8, N=4); exercises xfer_cnt when MUX_ARB_STATS_EN is defined.
module tb_mux_arb_n;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned SELW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_ready;
`ifdef MUX_ARB_STATS_EN
    logic [15:0]        xfer_cnt;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_arb_n #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
`ifdef MUX_ARB_STATS_EN
        .xfer_cnt  (xfer_cnt),
`endif
        .out_ready (out_ready)
    );

    typedef struct {
        logic               rst;
        logic               mode;
        logic [SELW-1:0]    sel;
        logic [N-1:0]       in_valid;
        logic [N*WIDTH-1:0] in_data;
        logic               out_ready;
        logic [N-1:0]       exp_in_ready;
        logic               exp_valid;
        logic [WIDTH-1:0]   exp_data;
        logic [SELW-1:0]    exp_ch;
    } vec_t;

    localparam logic [N*WIDTH-1:0] DA = {8'h13, 8'hA5, 8'h11, 8'h10};
    localparam logic [N*WIDTH-1:0] DB = {8'h13, 8'h12, 8'h11, 8'h10};

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic m, input logic [SELW-1:0] s,
                       input logic [N-1:0] iv, input logic [N*WIDTH-1:0] d, input logic ordy,
                       input logic [N-1:0] eir, input logic ev, input logic [WIDTH-1:0] ed,
                       input logic [SELW-1:0] ec);
        vec_t v;
        v.rst = r; v.mode = m; v.sel = s; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
        v.exp_in_ready = eir; v.exp_valid = ev; v.exp_data = ed; v.exp_ch = ec;
        vecs.push_back(v);
    endtask

    // Drive one cycle: check combinational in_ready, clock, then check registered outputs
    task automatic step(input string tag, input logic r, input logic m, input logic [SELW-1:0] s,
                        input logic [N-1:0] iv, input logic [N*WIDTH-1:0] d, input logic ordy,
                        input logic [N-1:0] eir, input logic ev, input logic [WIDTH-1:0] ed,
                        input logic [SELW-1:0] ec);
        rst = r; mode = m; sel = s; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'(eir));
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, " out_data"}, 32'(out_data), 32'(ed));
        check({tag, " out_ch"}, 32'(out_ch), 32'(ec));
    endtask

    initial begin
        // reset with all channels requesting
        add(1, 0, 0, 4'hF, DA, 1, 4'b0000, 0, 8'h00, 0);
        add(1, 0, 0, 4'hF, DA, 1, 4'b0000, 0, 8'h00, 0);
        // fixed select
        add(0, 0, 2, 4'hF, DA, 1, 4'b0100, 1, 8'hA5, 2);
        add(0, 0, 2, 4'hF, DA, 1, 4'b0100, 1, 8'hA5, 2);
        add(0, 0, 3, 4'hF, DA, 1, 4'b1000, 1, 8'h13, 3);
        add(0, 0, 1, 4'b0001, DA, 1, 4'b0000, 0, 8'h13, 3);
        add(0, 0, 0, 4'b0001, DA, 0, 4'b0001, 1, 8'h10, 0);
        // round-robin fairness, ptr still 0
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 4'hF, DB, 1, 4'(1 << (i % 4)), 1, 8'(8'h10 + i % 4), 2'(i % 4));
        // skip: move ptr to 1, then 1001 -> 3 then 0
        add(0, 1, 0, 4'b0001, DB, 1, 4'b0001, 1, 8'h10, 0);
        add(0, 1, 0, 4'b1001, DB, 1, 4'b1000, 1, 8'h13, 3);
        add(0, 1, 0, 4'b1001, DB, 1, 4'b0001, 1, 8'h10, 0);
        // backpressure 3 cycles, then full-rate release
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 4'hF, DB, 0, 4'b0000, 1, 8'h10, 0);
        add(0, 1, 0, 4'hF, DB, 1, 4'b0010, 1, 8'h11, 1);
        add(0, 1, 0, 4'hF, DB, 1, 4'b0100, 1, 8'h12, 2);
        add(0, 1, 0, 4'hF, DB, 1, 4'b1000, 1, 8'h13, 3);
        // mode change while held does not alter word; drain with no requests
        add(0, 0, 0, 4'hF, DB, 0, 4'b0000, 1, 8'h13, 3);
        add(0, 0, 0, 4'b0000, DB, 1, 4'b0000, 0, 8'h13, 3);
        // reset mid-transfer discards word and returns ptr to 0
        add(0, 1, 0, 4'hF, DB, 0, 4'b0001, 1, 8'h10, 0);
        add(1, 1, 0, 4'hF, DB, 0, 4'b0000, 0, 8'h00, 0);
        add(0, 1, 0, 4'hF, DB, 1, 4'b0001, 1, 8'h10, 0);

        foreach (vecs[k])
            step($sformatf("vec%0d", k), vecs[k].rst, vecs[k].mode, vecs[k].sel, vecs[k].in_valid,
                 vecs[k].in_data, vecs[k].out_ready, vecs[k].exp_in_ready, vecs[k].exp_valid,
                 vecs[k].exp_data, vecs[k].exp_ch);

        // fixed-mode stream on ch1 leaves ptr at 1; switching to rr resumes at ch1
        step("fix_s0", 0, 0, 1, 4'hF, DB, 1, 4'b0010, 1, 8'h11, 1);
        step("fix_s1", 0, 0, 1, 4'hF, DB, 1, 4'b0010, 1, 8'h11, 1);
        step("fix_s2", 0, 0, 1, 4'hF, DB, 1, 4'b0010, 1, 8'h11, 1);
        step("rr_resume", 0, 1, 0, 4'hF, DB, 1, 4'b0010, 1, 8'h11, 1);
        step("rr_next", 0, 1, 0, 4'hF, DB, 1, 4'b0100, 1, 8'h12, 2);

`ifdef MUX_ARB_STATS_EN
        // counter preload via streaming transfers, then observe the wrap
        step("st_rst", 1, 1, 0, 4'hF, DB, 1, 4'b0000, 0, 8'h00, 0);
        check("st_cnt_rst", 32'(xfer_cnt), 32'h0);
        rst = 0;
        @(posedge clk);
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        check("st_cnt_pre", 32'(xfer_cnt), 32'hFFFE);
        @(posedge clk); #1;
        check("st_cnt_0", 32'(xfer_cnt), 32'hFFFF);
        @(posedge clk); #1;
        check("st_cnt_1", 32'(xfer_cnt), 32'h0000);
        @(posedge clk); #1;
        check("st_cnt_2", 32'(xfer_cnt), 32'h0001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
